// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - decoder/ALU to condition unit interface
interface cond_unit_if #(
    parameter int CW = 16
);
    logic          En;
    logic [3:0]    Cond;
    logic [3:0]    ALUFlags;
    logic [1:0]    FlagW;
    logic          PCS;
    logic          RegW;
    logic          MemW;
    logic          NoWrite;
    logic          CountClr;
    logic          PCSrc;
    logic          RegWrite;
    logic          MemWrite;
    logic          CondEx;
    logic [3:0]    Flags;
    logic [CW-1:0] ExecCount;
    logic [CW-1:0] SquashCount;

    modport master (
        output En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CountClr,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
    );

    modport slave (
        input  En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CountClr,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
    );
endinterface

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition check and strobe gating
module cond_unit #(
    parameter int CW = 16
) (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);
    logic [3:0]    flags_q;
    logic [CW-1:0] exec_q;
    logic [CW-1:0] squash_q;
    logic          cond_ex;
    logic          fl_n;
    logic          fl_z;
    logic          fl_c;
    logic          fl_v;
    logic          retire_pass;

    assign fl_n = flags_q[3];
    assign fl_z = flags_q[2];
    assign fl_c = flags_q[1];
    assign fl_v = flags_q[0];

    // Condition decode looks only at the stored flags, so a flag-setting
    // instruction is itself conditioned on the previous flags.
    always_comb begin
        cond_ex = 1'b1;
        case (bus.Cond)
            4'b0000: cond_ex = fl_z;
            4'b0001: cond_ex = ~fl_z;
            4'b0010: cond_ex = fl_c;
            4'b0011: cond_ex = ~fl_c;
            4'b0100: cond_ex = fl_n;
            4'b0101: cond_ex = ~fl_n;
            4'b0110: cond_ex = fl_v;
            4'b0111: cond_ex = ~fl_v;
            4'b1000: cond_ex = fl_c & ~fl_z;
            4'b1001: cond_ex = ~fl_c | fl_z;
            4'b1010: cond_ex = (fl_n == fl_v);
            4'b1011: cond_ex = (fl_n != fl_v);
            4'b1100: cond_ex = ~fl_z & (fl_n == fl_v);
            4'b1101: cond_ex = fl_z | (fl_n != fl_v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign retire_pass     = bus.En & cond_ex;
    assign bus.CondEx      = cond_ex;
    assign bus.PCSrc       = retire_pass & bus.PCS;
    assign bus.RegWrite    = retire_pass & bus.RegW & ~bus.NoWrite;
    assign bus.MemWrite    = retire_pass & bus.MemW;
    assign bus.Flags       = flags_q;
    assign bus.ExecCount   = exec_q;
    assign bus.SquashCount = squash_q;

    // NZ and CV halves are written independently by a passing instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (retire_pass && bus.FlagW[1]) begin
                flags_q[3:2] <= bus.ALUFlags[3:2];
            end
            if (retire_pass && bus.FlagW[0]) begin
                flags_q[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // Executed/squashed counters wrap freely; clear overrides any increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (bus.CountClr) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (bus.En) begin
            if (cond_ex) begin
                exec_q <= exec_q + 1'b1;
            end else begin
                squash_q <= squash_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard testbench for cond_unit
module tb_cond_unit;
    localparam int CW = 4;

    logic clk;
    logic reset;

    cond_unit_if #(.CW(CW)) bus ();

    cond_unit #(.CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string tag;
        logic  condex;
        logic  pcsrc;
        logic  regwrite;
        logic  memwrite;
    } comb_rec_t;

    typedef struct {
        string         tag;
        logic [3:0]    flags;
        logic [CW-1:0] exec;
        logic [CW-1:0] squash;
    } state_rec_t;

    comb_rec_t  comb_q[$];
    state_rec_t state_q[$];

    int n_chk;
    int n_fail;

    logic [3:0]    m_flags;
    logic [CW-1:0] m_exec;
    logic [CW-1:0] m_squash;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ARM-style decode: cond[3:1] picks a base test, cond[0] inverts it.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    task automatic cycle(input string tag, input logic en, input logic [3:0] cond,
                         input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                         input logic regw, input logic memw, input logic nowr,
                         input logic clr);
        comb_rec_t  cr;
        state_rec_t sr;
        logic       pass;
        logic [3:0] nf;
        bus.En = en; bus.Cond = cond; bus.ALUFlags = alu; bus.FlagW = fw;
        bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw; bus.NoWrite = nowr;
        bus.CountClr = clr;
        pass = model_pass(cond, m_flags);
        cr.tag = tag;
        cr.condex = pass;
        cr.pcsrc = en & pass & pcs;
        cr.regwrite = en & pass & regw & ~nowr;
        cr.memwrite = en & pass & memw;
        comb_q.push_back(cr);
        nf = m_flags;
        if (en && pass && fw[1]) nf[3:2] = alu[3:2];
        if (en && pass && fw[0]) nf[1:0] = alu[1:0];
        m_flags = nf;
        if (clr) begin
            m_exec = '0; m_squash = '0;
        end else if (en && pass) begin
            m_exec = m_exec + 1'b1;
        end else if (en) begin
            m_squash = m_squash + 1'b1;
        end
        sr.tag = tag; sr.flags = m_flags; sr.exec = m_exec; sr.squash = m_squash;
        state_q.push_back(sr);
        #1;
        cr = comb_q.pop_front();
        check({cr.tag, ".condex"}, 32'(bus.CondEx), 32'(cr.condex));
        check({cr.tag, ".pcsrc"}, 32'(bus.PCSrc), 32'(cr.pcsrc));
        check({cr.tag, ".regwrite"}, 32'(bus.RegWrite), 32'(cr.regwrite));
        check({cr.tag, ".memwrite"}, 32'(bus.MemWrite), 32'(cr.memwrite));
        @(posedge clk);
        #1;
        sr = state_q.pop_front();
        check({sr.tag, ".flags"}, 32'(bus.Flags), 32'(sr.flags));
        check({sr.tag, ".exec"}, 32'(bus.ExecCount), 32'(sr.exec));
        check({sr.tag, ".squash"}, 32'(bus.SquashCount), 32'(sr.squash));
        @(negedge clk);
    endtask

    task automatic set_flags(input string tag, input logic [3:0] f);
        cycle(tag, 1'b1, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_flags = 4'b0; m_exec = '0; m_squash = '0;
        reset = 1'b0;
        bus.En = 1'b0; bus.Cond = 4'h0; bus.ALUFlags = 4'h0; bus.FlagW = 2'b00;
        bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
        bus.CountClr = 1'b0;
        #12;
        check("rst.flags", 32'(bus.Flags), 32'h0);
        check("rst.exec", 32'(bus.ExecCount), 32'h0);
        check("rst.squash", 32'(bus.SquashCount), 32'h0);
        check("rst.eq_condex", 32'(bus.CondEx), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        cycle("al_regw", 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("al_regw.exec_one", 32'(bus.ExecCount), 32'h1);

        set_flags("set_z", 4'b0100);
        cycle("eq_pass", 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("ne_fail", 1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        set_flags("set_nv", 4'b1001);
        cycle("ge_nv", 1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("gt_nv", 1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lt_nv", 1'b1, 4'hB, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("le_nv", 1'b1, 4'hD, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_flags("set_n", 4'b1000);
        cycle("ge_n", 1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lt_n", 1'b1, 4'hB, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_flags("set_c", 4'b0010);
        cycle("hi_c", 1'b1, 4'h8, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("ls_c", 1'b1, 4'h9, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_flags("set_zc", 4'b0110);
        cycle("hi_zc", 1'b1, 4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("ls_zc", 1'b1, 4'h9, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        set_flags("clr_flags", 4'b0000);
        cycle("cv_only", 1'b1, 4'hE, 4'hF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cv_only.const", 32'(bus.Flags), 32'h3);
        cycle("eq_fail_nowr", 1'b1, 4'h0, 4'hF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("eq_fail_nowr.const", 32'(bus.Flags), 32'h3);

        cycle("nowrite", 1'b1, 4'hE, 4'hA, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("stall", 1'b0, 4'hE, 4'h5, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall.const", 32'(bus.Flags), 32'hA);

        for (int i = 0; i < 48; i++) begin
            cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                  4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 15) == 0));
        end

        cycle("clr_wins", 1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_wins.exec0", 32'(bus.ExecCount), 32'h0);
        for (int i = 0; i < 15; i++) begin
            cycle($sformatf("wrap%0d", i), 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("wrap.full", 32'(bus.ExecCount), 32'hF);
        cycle("wrap_last", 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap.zero", 32'(bus.ExecCount), 32'h0);

        set_flags("pre_areset", 4'b1111);
        cycle("squash_one", 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("areset.flags", 32'(bus.Flags), 32'h0);
        check("areset.exec", 32'(bus.ExecCount), 32'h0);
        check("areset.squash", 32'(bus.SquashCount), 32'h0);
        m_flags = 4'b0; m_exec = '0; m_squash = '0;
        @(negedge clk);
        reset = 1'b1;
        cycle("post_areset", 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
